huff_decode: RTL

- Huffman bitstream decoder: the receive-side counterpart of the symbol-count / Huffman-encode path.
- Accepts a code table of up to 10 symbols (values 0-9, each a code word plus length), then consumes a serial MSB-first bitstream one bit per cycle.
- Emits one 4-bit symbol per completed code word and stops after a programmed symbol count.
- Feeds symbols back into the same 4-bit Data_in style symbol path the histogram logic uses, so round-trip checks are possible.

---
 rtl/huff_decode_pkg.sv | 25 ++
 rtl/huff_match.sv | 30 +++
 rtl/huff_decode.sv | 136 +++++++++++++
 3 files changed

// File: rtl/huff_decode_pkg.sv
// Shared constants, state encoding and helpers for the Huffman bitstream decoder.
// Symbols are 4 bits wide. Code words are right-aligned in a MAX_LEN-bit field.
package huff_decode_pkg;

   localparam int NSYM    = 10;
   localparam int MAX_LEN = 9;
   localparam int SYM_W   = 4;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      DONE   = 2'd2,
      ERROR  = 2'd3
   } state_t;

   // Mask selecting the low 'len' bits of a right-aligned code word.
   function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
      logic [MAX_LEN-1:0] m;
      for (int i = 0; i < MAX_LEN; i++) m[i] = (i < int'(len));
      return m;
   endfunction

endpackage

// File: rtl/huff_match.sv
// Combinational code-word matcher: compares one candidate against every table entry.
// When several entries match, the lowest index wins.
module huff_match
   import huff_decode_pkg::*;
(
   input  logic [MAX_LEN-1:0]       i_cand,
   input  logic [LEN_W-1:0]         i_len,
   input  logic [NSYM*MAX_LEN-1:0]  i_tbl_code,
   input  logic [NSYM*LEN_W-1:0]    i_tbl_len,
   output logic                     o_hit,
   output logic [SYM_W-1:0]         o_idx
);

   logic [MAX_LEN-1:0] w_mask;

   // Scanning from the top down lets the lowest matching index overwrite the others.
   always_comb begin
      o_hit  = 1'b0;
      o_idx  = '0;
      w_mask = len_mask(i_len);
      for (int i = NSYM - 1; i >= 0; i--) begin
         if ((i_tbl_len[i*LEN_W +: LEN_W] == i_len) &&
             ((i_tbl_code[i*MAX_LEN +: MAX_LEN] & w_mask) == (i_cand & w_mask))) begin
            o_hit = 1'b1;
            o_idx = SYM_W'(i);
         end
      end
   end

endmodule

// File: rtl/huff_decode.sv
// Huffman bitstream decoder. It takes one MSB-first bit per cycle and emits a symbol on the
// edge that samples the last bit of its code word. It stops after the programmed symbol count.
module huff_decode
   import huff_decode_pkg::*;
(
   input  logic               Clk_in,
   input  logic               nRst,
   input  logic               Start,
   input  logic [CNT_W-1:0]   Num_total,
   input  logic               Tbl_we,
   input  logic [SYM_W-1:0]   Tbl_sym,
   input  logic [MAX_LEN-1:0] Tbl_code,
   input  logic [LEN_W-1:0]   Tbl_len,
   input  logic               Bit_in,
   input  logic               Bit_valid,
   output logic               Bit_ready,
   output logic [SYM_W-1:0]   Sym_out,
   output logic               Sym_valid,
   output logic [CNT_W-1:0]   Sym_cnt,
   output logic               Done,
   output logic               Err
);

   state_t                  r_state, w_state_nxt;
   logic [MAX_LEN-1:0]      r_code [NSYM];
   logic [LEN_W-1:0]        r_tlen [NSYM];
   logic [NSYM*MAX_LEN-1:0] w_tbl_code;
   logic [NSYM*LEN_W-1:0]   w_tbl_len;
   logic [MAX_LEN-2:0]      r_acc;
   logic [LEN_W-1:0]        r_len, w_len_cand;
   logic [MAX_LEN-1:0]      w_cand;
   logic [CNT_W-1:0]        r_cnt, r_total, w_cnt_inc;
   logic [SYM_W-1:0]        r_sym, w_idx;
   logic                    r_sym_vld, w_hit, w_take, w_last_bit;

   assign w_take     = (r_state == DECODE) && Bit_valid;
   assign w_cand     = {r_acc, Bit_in};
   assign w_len_cand = r_len + LEN_W'(1);
   assign w_last_bit = (w_len_cand == LEN_W'(MAX_LEN));
   assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

   always_comb begin
      w_tbl_code = '0;
      w_tbl_len  = '0;
      for (int i = 0; i < NSYM; i++) begin
         w_tbl_code[i*MAX_LEN +: MAX_LEN] = r_code[i];
         w_tbl_len[i*LEN_W +: LEN_W]      = r_tlen[i];
      end
   end

   huff_match u_match (
      .i_cand     (w_cand),
      .i_len      (w_len_cand),
      .i_tbl_code (w_tbl_code),
      .i_tbl_len  (w_tbl_len),
      .o_hit      (w_hit),
      .o_idx      (w_idx)
   );

   always_ff @(posedge Clk_in or negedge nRst) begin
      if (!nRst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Start overrides everything. A zero count skips DECODE entirely.
   always_comb begin
      w_state_nxt = r_state;
      Bit_ready   = (r_state == DECODE);
      Done        = (r_state == DONE);
      Err         = (r_state == ERROR);
      if (Start) begin
         w_state_nxt = (Num_total == '0) ? DONE : DECODE;
      end else if (w_take) begin
         if (w_hit) begin
            if (w_cnt_inc == r_total) w_state_nxt = DONE;
         end else if (w_last_bit) begin
            w_state_nxt = ERROR;
         end
      end
   end

   always_ff @(posedge Clk_in or negedge nRst) begin
      if (!nRst) begin
         r_acc     <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_total   <= '0;
         r_sym     <= '0;
         r_sym_vld <= 1'b0;
      end else begin
         r_sym_vld <= 1'b0;
         if (Start) begin
            r_acc   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_total <= Num_total;
         end else if (w_take) begin
            if (w_hit) begin
               r_sym     <= w_idx;
               r_sym_vld <= 1'b1;
               r_cnt     <= w_cnt_inc;
               r_acc     <= '0;
               r_len     <= '0;
            end else if (w_last_bit) begin
               r_acc <= '0;
               r_len <= '0;
            end else begin
               r_acc <= w_cand[MAX_LEN-2:0];
               r_len <= w_len_cand;
            end
         end
      end
   end

   // The table is frozen while a stream is being decoded.
   always_ff @(posedge Clk_in or negedge nRst) begin
      if (!nRst) begin
         for (int i = 0; i < NSYM; i++) begin
            r_code[i] <= '0;
            r_tlen[i] <= '0;
         end
      end else if (Tbl_we && (r_state != DECODE)) begin
         for (int i = 0; i < NSYM; i++) begin
            if (Tbl_sym == SYM_W'(i)) begin
               r_code[i] <= Tbl_code;
               r_tlen[i] <= Tbl_len;
            end
         end
      end
   end

   assign Sym_out   = r_sym;
   assign Sym_valid = r_sym_vld;
   assign Sym_cnt   = r_cnt;

endmodule
